// File: rtl/cnn_top.sv
// cnn_top: fixed-function single-channel CNN inference core.
//
// Reduces one IMG_DIM x IMG_DIM image of signed DATA_W-bit pixels to one
// OUT_W-bit score: 3x3 convolution with kernel [1 2 1; 2 4 2; 1 2 1]
// (valid mode, stride 1), ReLU, 2x2/stride-2 max-pool, then an unsigned
// sum of all pooled values.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset (aborts any computation)
//   enable     start request, level-sampled in IDLE; holds the result in DONE
//   input_img  image, pixel (r,c) at index r*IMG_DIM+c, sampled on capture edge
//   value      final score, valid while done=1, retained after done drops
//   done       result-valid flag
//
// Schedule: capture (1 edge), CONV (one map pixel per edge), POOL (one
// block per edge), FINISH (1 edge) -> done rises on edge 47 for IMG_DIM=8.
module cnn_top #(
  parameter int IMG_DIM = 8,
  parameter int DATA_W  = 32,
  parameter int OUT_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [DATA_W-1:0] input_img [IMG_DIM*IMG_DIM],
  output logic [OUT_W-1:0]  value,
  output logic              done
);

  localparam int IMG_N    = IMG_DIM * IMG_DIM;
  localparam int MAP_DIM  = IMG_DIM - 2;
  localparam int FEAT_N   = MAP_DIM * MAP_DIM;
  localparam int POOL_DIM = MAP_DIM / 2;
  localparam int IMG_AW   = $clog2(IMG_N);
  localparam int FEAT_AW  = $clog2(FEAT_N);
  localparam int CW       = (MAP_DIM > 1) ? $clog2(MAP_DIM) : 1;
  localparam int PW       = (POOL_DIM > 1) ? $clog2(POOL_DIM) : 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CONV   = 3'd1,
    POOL   = 3'd2,
    FINISH = 3'd3,
    DONE   = 3'd4
  } state_t;

  // Kernel weights are all powers of two: 1 on corners, 2 on edges, 4 centre.
  function automatic int kern_shift(input int i, input int j);
    kern_shift = ((i == 32'sd1) ? 32'sd1 : 32'sd0) + ((j == 32'sd1) ? 32'sd1 : 32'sd0);
  endfunction

  function automatic logic [DATA_W-1:0] max2(input logic [DATA_W-1:0] a,
                                             input logic [DATA_W-1:0] b);
    // Inputs are post-ReLU (non-negative), so an unsigned compare is exact.
    max2 = (a > b) ? a : b;
  endfunction

  state_t state_r, state_next_s;

  logic [DATA_W-1:0] img_r  [IMG_N];
  logic [DATA_W-1:0] feat_r [FEAT_N];

  logic [CW-1:0]    conv_r_r, conv_c_r;
  logic [PW-1:0]    pool_p_r, pool_q_r;
  logic [OUT_W-1:0] acc_r;

  logic capture_s, conv_en_s, pool_en_s, finish_s, release_s;
  logic conv_last_col_s, conv_last_s, pool_last_col_s, pool_last_s;

  logic [IMG_AW-1:0]  img_base_s, img_idx_s;
  logic [DATA_W-1:0]  conv_sum_s, relu_s;
  logic [FEAT_AW-1:0] feat_idx_s, pool_base_s;
  logic [DATA_W-1:0]  pool_max_s;

  assign conv_last_col_s = (conv_c_r == CW'(MAP_DIM - 1));
  assign conv_last_s     = conv_last_col_s && (conv_r_r == CW'(MAP_DIM - 1));
  assign pool_last_col_s = (pool_q_r == PW'(POOL_DIM - 1));
  assign pool_last_s     = pool_last_col_s && (pool_p_r == PW'(POOL_DIM - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE:    state_next_s = enable ? CONV : IDLE;
      CONV:    state_next_s = conv_last_s ? POOL : CONV;
      POOL:    state_next_s = pool_last_s ? FINISH : POOL;
      FINISH:  state_next_s = DONE;
      DONE:    state_next_s = enable ? DONE : IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // Per-state datapath strobes.
  always_comb begin
    capture_s = 1'b0;
    conv_en_s = 1'b0;
    pool_en_s = 1'b0;
    finish_s  = 1'b0;
    release_s = 1'b0;
    case (state_r)
      IDLE:    capture_s = enable;
      CONV:    conv_en_s = 1'b1;
      POOL:    pool_en_s = 1'b1;
      FINISH:  finish_s  = 1'b1;
      DONE:    release_s = ~enable;
      default: capture_s = 1'b0;
    endcase
  end

  // Convolution window: the 3x3 window's top-left pixel is (r,c), so each tap
  // sits at a fixed offset i*IMG_DIM+j from the window base. Sums wrap mod 2^32.
  always_comb begin
    img_base_s = IMG_AW'(conv_r_r) * IMG_AW'(IMG_DIM) + IMG_AW'(conv_c_r);
    img_idx_s  = '0;
    conv_sum_s = '0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        img_idx_s  = img_base_s + IMG_AW'(i * IMG_DIM + j);
        conv_sum_s = conv_sum_s + (img_r[img_idx_s] << kern_shift(i, j));
      end
    end
    if (conv_sum_s[DATA_W-1]) begin
      relu_s = '0;
    end else begin
      relu_s = conv_sum_s;
    end
    feat_idx_s = FEAT_AW'(conv_r_r) * FEAT_AW'(MAP_DIM) + FEAT_AW'(conv_c_r);
  end

  // Pool block (p,q) starts at map pixel (2p,2q).
  always_comb begin
    pool_base_s = FEAT_AW'(pool_p_r) * FEAT_AW'(2 * MAP_DIM) + FEAT_AW'(pool_q_r) * FEAT_AW'(2);
    pool_max_s  = max2(max2(feat_r[pool_base_s], feat_r[pool_base_s + FEAT_AW'(1)]),
                       max2(feat_r[pool_base_s + FEAT_AW'(MAP_DIM)],
                            feat_r[pool_base_s + FEAT_AW'(MAP_DIM + 1)]));
  end

  // Image and feature buffers; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (capture_s && !rst) begin
      img_r <= input_img;
    end
    if (conv_en_s && !rst) begin
      feat_r[feat_idx_s] <= relu_s;
    end
  end

  // Counters, accumulator and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      conv_r_r <= '0;
      conv_c_r <= '0;
      pool_p_r <= '0;
      pool_q_r <= '0;
      acc_r    <= '0;
      value    <= '0;
      done     <= 1'b0;
    end else begin
      if (capture_s) begin
        conv_r_r <= '0;
        conv_c_r <= '0;
        pool_p_r <= '0;
        pool_q_r <= '0;
        acc_r    <= '0;
      end
      if (conv_en_s) begin
        if (conv_last_s) begin
          conv_r_r <= '0;
          conv_c_r <= '0;
        end else if (conv_last_col_s) begin
          conv_r_r <= conv_r_r + CW'(1);
          conv_c_r <= '0;
        end else begin
          conv_c_r <= conv_c_r + CW'(1);
        end
      end
      if (pool_en_s) begin
        acc_r <= acc_r + OUT_W'(pool_max_s);
        if (pool_last_s) begin
          pool_p_r <= '0;
          pool_q_r <= '0;
        end else if (pool_last_col_s) begin
          pool_p_r <= pool_p_r + PW'(1);
          pool_q_r <= '0;
        end else begin
          pool_q_r <= pool_q_r + PW'(1);
        end
      end
      if (finish_s) begin
        value <= acc_r;
        done  <= 1'b1;
      end
      if (release_s) begin
        done <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cnn_top.sv
// Directed self-checking bench for cnn_top. Each scenario task drives its own
// stimulus and compares outputs against hand-computed expected values.
module tb_cnn_top;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [31:0] img [64];
  logic [31:0] value;
  logic        done;

  int checks = 0;
  int failures = 0;

  cnn_top #(.IMG_DIM(8), .DATA_W(32), .OUT_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .input_img (img),
    .value     (value),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic fill_img(input logic [31:0] pix);
    for (int k = 0; k < 64; k++) img[k] = pix;
  endtask

  // Capture on the next edge, then expect done low through edge 46 and the
  // result on edge 47. The image is scrambled right after capture.
  task automatic run_image(input logic [31:0] exp_val, input string name);
    bit early;
    early = 1'b0;
    rst = 1'b0;
    enable = 1'b1;
    @(posedge clk); #1;
    fill_img(32'h0000_0007);
    for (int e = 2; e <= 46; e++) begin
      @(posedge clk); #1;
      if (done !== 1'b0) early = 1'b1;
    end
    checks++;
    if (early) begin
      failures++;
      $display("FAIL %s_done_early: done seen high before edge 47 (required 0)", name);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL %s_done: got %b required 1", name, done);
    end
    checks++;
    if (value !== exp_val) begin
      failures++;
      $display("FAIL %s_value: got %0d required %0d", name, value, exp_val);
    end
  endtask

  // Hold enable high in DONE, then drop it and expect done to clear.
  task automatic hold_and_release(input logic [31:0] exp_val, input string name);
    enable = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b1 || value !== exp_val) begin
        failures++;
        $display("FAIL %s_hold: done=%b value=%0d required done=1 value=%0d", name, done, value, exp_val);
      end
    end
    enable = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL %s_release_done: got %b required 0", name, done);
    end
    checks++;
    if (value !== exp_val) begin
      failures++;
      $display("FAIL %s_release_value: got %0d required %0d", name, value, exp_val);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    enable = 1'b1;
    for (int k = 0; k < 64; k++) img[k] = 'x;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL reset_done: got %b required 0", done);
    end
    checks++;
    if (value !== 32'd0) begin
      failures++;
      $display("FAIL reset_value: got %0d required 0", value);
    end
  endtask

  task automatic test_all_ones();
    fill_img(32'd1);
    run_image(32'd144, "ones");
    hold_and_release(32'd144, "ones");
  endtask

  task automatic test_impulse();
    fill_img(32'd0);
    img[3*8+3] = 32'd100;
    run_image(32'd900, "impulse");
    hold_and_release(32'd900, "impulse");
  endtask

  // Corner pixels reach only one map pixel each; the negative pixel's
  // contributions are clipped by ReLU: 10 + 5 = 15.
  task automatic test_corners();
    fill_img(32'd0);
    img[7*8+0] = 32'd10;
    img[0*8+7] = 32'd5;
    img[4*8+5] = 32'hFFFF_FC18;
    run_image(32'd15, "corners");
    hold_and_release(32'd15, "corners");
  endtask

  task automatic test_negative();
    fill_img(32'hFFFF_FFFF);
    run_image(32'd0, "negative");
    hold_and_release(32'd0, "negative");
  endtask

  task automatic test_overflow();
    fill_img(32'h1000_0000);
    run_image(32'd0, "overflow");
    hold_and_release(32'd0, "overflow");
  endtask

  task automatic test_back_to_back();
    // Idle with enable low: nothing starts.
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL idle_done: got %b required 0", done);
    end
    fill_img(32'd2);
    run_image(32'd288, "twos");
    hold_and_release(32'd288, "twos");
  endtask

  task automatic test_abort();
    fill_img(32'd3);
    enable = 1'b1;
    @(posedge clk); #1;              // capture
    repeat (20) @(posedge clk);      // 20 CONV cycles
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL abort_done: got %b required 0", done);
    end
    checks++;
    if (value !== 32'd0) begin
      failures++;
      $display("FAIL abort_value: got %0d required 0", value);
    end
    fill_img(32'd1);
    run_image(32'd144, "after_abort");
    hold_and_release(32'd144, "after_abort");
  endtask

  initial begin
    test_reset();
    test_all_ones();
    test_impulse();
    test_corners();
    test_negative();
    test_overflow();
    test_back_to_back();
    test_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cnn_top.md
# cnn_top

Fixed-function single-channel CNN inference core that reduces one 8x8 image of 32-bit signed pixels to a single 32-bit score. The pipeline is a 3x3 convolution with a hard-wired kernel, then ReLU, 2x2 max-pool, and a unit-weight dense sum. It is the compute core of one accelerator tile: the tile controller presents a whole image, pulses `enable`, and waits for `done`.

## Interface
- IMG_DIM, 8, image side length; the image has IMG_DIM*IMG_DIM pixels.
- DATA_W, 32, pixel width, two's complement signed.
- OUT_W, 32, result width.

- clk  input  1  single clock, rising-edge.
- rst  input  1  synchronous, active-high reset; one clock, reset is synchronous and active-high.
- enable  input  1  start request; level-sampled in IDLE, also holds the result in DONE.
- input_img  input  32 x 64 unpacked array  pixel (r,c) at index r*8+c; sampled only on the capture edge.
- value  output  32  final score, valid while done=1.
- done  output  1  result-valid flag.

## Operation
- Kernel K, row-major, fixed: [1 2 1; 2 4 2; 1 2 1].
- Convolution: valid mode, stride 1, no padding, giving a 6x6 map. conv(r,c) = sum over i,j in 0..2 of K[i][j]*img[r+i][c+j].
- Conv arithmetic: signed, accumulated modulo 2^32. ReLU treats the 32-bit result as signed and replaces negatives with 0.
- Pool: 2x2 max, stride 2, over the 6x6 map, giving a 3x3 map. Block (p,q) covers map rows 2p..2p+1 and columns 2q..2q+1.
- Dense: value = sum of the 9 pooled values, unsigned, modulo 2^32.
- Internal storage: a 64x32 image buffer and a 36x32 feature buffer (or equivalent). A pooled-value accumulator is permitted.
- FSM states:
  - IDLE: done=0. If enable=1, latch input_img into the image buffer and go to CONV.
  - CONV: 36 cycles, one output pixel per cycle in raster order (r outer, c inner). Each cycle uses 9 multiply-adds. Then go to POOL.
  - POOL: 9 cycles, one block per cycle in raster order, adding the block max into the accumulator. Then go to FINISH.
  - FINISH: 1 cycle; value <= accumulator, done <= 1. Then go to DONE.
  - DONE: done=1 and value held while enable=1. When enable=0, go to IDLE and clear done on that edge; value keeps the last result.
- enable is ignored during CONV, POOL and FINISH; a started computation always completes.
- input_img changes after the capture edge have no effect on the current computation.
- If enable is still 1 in DONE, no new computation starts until enable has dropped (returned to IDLE) and is sampled high again.

## Timing
- Reset (rst=1 at a rising edge): state=IDLE, value=0, done=0, accumulator=0, counters=0. Reset dominates enable.
- Reset during any state aborts the operation; the same reset values apply on the next edge.
- Latency: capture edge = edge 1; CONV = edges 2–37; POOL = edges 38–46; FINISH = edge 47. value and done update at edge 47.
- done rises exactly 47 edges after and including the capture edge, and stays high without glitching until the edge after enable is seen low in DONE.
- The first capture after reset release happens at the first rising edge with rst=0 and enable=1.

## Test plan
- Reset: hold rst=1 with enable=1 and input_img=X for 2 cycles -> done=0, value=0.
- All ones: release rst with enable=1 and all pixels 1 -> done=1 on edge 47 after capture, value=144 (conv=16 everywhere).
- Impulse: pixel (3,3)=100, all others 0 -> pooled values 100, 200, 200, 400, rest 0 -> value=900.
- Negative and overflow: all pixels -1 -> value=0 (ReLU). All pixels 0x10000000 -> conv wraps to 0 -> value=0.
- Handshake: after done, drop enable -> done=0 next edge, value retained. Apply new image all 2 with enable=1 -> value=288.
- Abort: assert rst at cycle 20 of CONV -> done=0, value=0. Then all ones with enable -> value=144 at the full 47-edge latency.
